wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
Shares the single register-file write port between the in-order pipeline writeback (MEM_WB output) and the multi-cycle mul/div unit. Pipeline writeback always has priority. Mul/div results are buffered in a small FIFO and drained into idle writeback slots. A starvation guard requests a one-slot pipeline stall when a buffered result has waited too long. A lookup port tells the hazard unit which registers still have pending writes.

Parameters:
DEPTH, 2, mul/div result FIFO entries (power of two, >=2)
STARVE_LIMIT, 4, cycles a non-empty FIFO head may go ungranted before stall_req asserts (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
wb_regDest  in  5  pipeline writeback destination; 0 = no write
wb_result  in  32  pipeline writeback data
md_valid  in  1  mul/div result valid
md_regDest  in  5  mul/div destination register
md_result  in  32  mul/div result data
md_ready  out  1  FIFO can accept (combinational: count != DEPTH)
q_addr  in  5  hazard-unit query register
q_busy  out  1  combinational: some FIFO entry targets q_addr (q_addr != 0)
stall_req  out  1  registered request for the pipeline to insert one writeback bubble
rf_we  out  1  registered register-file write enable
rf_waddr  out  5  registered write address
rf_wdata  out  32  registered write data

Behaviour:
- Reset (rst low, async): rf_we=0, rf_waddr=0, rf_wdata=0, stall_req=0, FIFO empty (pointers and count 0), starve counter 0. Reset mid-operation discards buffered results.
- Pipeline slot busy when wb_regDest != 0. Grant per cycle:
  - Pipeline busy: next edge rf_we=1, rf_waddr=wb_regDest, rf_wdata=wb_result. FIFO head is not popped.
  - Pipeline idle, FIFO non-empty: pop the head; next edge rf_we=1 with the head's address and data.
  - Both idle: next edge rf_we=0; rf_waddr and rf_wdata hold their previous values.
- Latency is exactly one cycle from input to rf_* for both sources.
- Push: md_valid && md_ready && md_regDest != 0 writes a FIFO entry. md_valid with md_regDest=0 is handshaken (consumed) but not stored.
- No bypass: an entry pushed in cycle N is first eligible for grant in cycle N+1.
- Push and pop in the same cycle are both legal; count is unchanged.
- md_ready is low only when count == DEPTH. A push is never lost.
- Pointers wrap modulo DEPTH.
- FIFO grant order is strict FIFO order.
- q_busy covers valid entries only. An entry being popped this cycle still counts as busy. An entry being pushed this cycle does not yet count.
- Starve counter:
  - Increments each cycle the FIFO is non-empty and the head is not granted.
  - Clears on any FIFO grant or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
  - stall_req is set on the edge where the counter reaches STARVE_LIMIT. It stays high until the edge after the next FIFO grant, then clears.
- Pipeline contract: while stall_req=1, the pipeline presents wb_regDest=0 within 2 cycles. The arbiter does not rely on this for correctness, only for forward progress.
- Write-after-write ordering between the two sources is the hazard unit's job via q_busy. The arbiter never reorders or drops a stored entry.

Test Plan:
- Reset: drive random inputs, pulse rst low asynchronously mid-cycle -> rf_we=0, rf_waddr=0, rf_wdata=0, stall_req=0, md_ready=1 immediately; a previously buffered entry is never written.
- Pipeline-only: wb_regDest=5, wb_result=0xDEADBEEF in cycle N -> cycle N+1: rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF. Then wb_regDest=0 -> rf_we=0, rf_waddr stays 5.
- Idle-slot drain: push md r7=0x11 in cycle N with wb_regDest=0 throughout -> no write in N+1; rf_we=1, rf_waddr=7 in N+2. q_busy(q_addr=7)=0 in N, 1 in N+1, 0 in N+2.
- Full/ordering: with DEPTH=2 and the pipeline busy, push r1=0xA, then r2=0xB -> md_ready=0, and a third md_valid is held off. Release the pipeline -> writes r1 then r2 on consecutive cycles; md_ready returns to 1 after the first pop.
- Starvation: one entry buffered, pipeline busy every cycle -> stall_req=1 after 4 ungranted cycles. Drop wb_regDest to 0 -> entry written next edge, stall_req=0 one edge after.
- Zero dest / simultaneous: md_valid with md_regDest=0 -> md_ready=1, count unchanged, nothing written. Push at count=1 in the same cycle as a pop -> count stays 1 and order is preserved.

Source files
------------

// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if: writeback, mul/div, hazard-query and register-file write signals of the arbiter.
interface wb_port_arbiter_if;
  logic [4:0]  wb_regDest;
  logic [31:0] wb_result;
  logic        md_valid;
  logic [4:0]  md_regDest;
  logic [31:0] md_result;
  logic        md_ready;
  logic [4:0]  q_addr;
  logic        q_busy;
  logic        stall_req;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  modport slave (
    input  wb_regDest, wb_result, md_valid, md_regDest, md_result, q_addr,
    output md_ready, q_busy, stall_req, rf_we, rf_waddr, rf_wdata
  );
  modport master (
    output wb_regDest, wb_result, md_valid, md_regDest, md_result, q_addr,
    input  md_ready, q_busy, stall_req, rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between pipeline writeback (priority)
// and a FIFO of mul/div results drained into idle slots, with a starvation stall request.
module wb_port_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic              clk,
  input logic              rst,
  wb_port_arbiter_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [4:0]       r_mem_addr [DEPTH];
  logic [31:0]      r_mem_data [DEPTH];
  logic [AW-1:0]    r_wp, r_rp;
  logic [CW-1:0]    r_cnt;
  logic [SW-1:0]    r_starve;
  logic             r_stall, r_popped, r_we;
  logic [4:0]       r_waddr;
  logic [31:0]      r_wdata;
  logic [SW-1:0]    w_starve_nxt;
  logic             w_pipe, w_empty, w_ready, w_pop, w_push;
  logic [AW-1:0]    w_off [DEPTH];
  logic [DEPTH-1:0] w_hit;
  assign w_pipe       = bus.wb_regDest != 5'd0;
  assign w_empty      = r_cnt == '0;
  assign w_ready      = r_cnt != CW'(DEPTH);
  assign w_pop        = !w_pipe && !w_empty;
  assign w_push       = bus.md_valid && w_ready && bus.md_regDest != 5'd0;
  assign w_starve_nxt = (w_empty || w_pop) ? '0 :
                        (r_starve == SW'(STARVE_LIMIT)) ? r_starve : r_starve + SW'(1);
  // An entry is live when its distance from the read pointer is below the fill count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_hit
    assign w_off[i] = AW'(i) - r_rp;
    assign w_hit[i] = (CW'(w_off[i]) < r_cnt) && (r_mem_addr[i] == bus.q_addr);
  end
  assign bus.md_ready  = w_ready;
  assign bus.q_busy    = (bus.q_addr != 5'd0) && |w_hit;
  assign bus.stall_req = r_stall;
  assign bus.rf_we     = r_we;
  assign bus.rf_waddr  = r_waddr;
  assign bus.rf_wdata  = r_wdata;
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_addr[r_wp] <= bus.md_regDest;
      r_mem_data[r_wp] <= bus.md_result;
    end
  end
  // stall_req drops one edge after a FIFO grant, unless the counter re-saturates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp     <= '0;
      r_rp     <= '0;
      r_cnt    <= '0;
      r_starve <= '0;
      r_stall  <= 1'b0;
      r_popped <= 1'b0;
      r_we     <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop) r_rp <= r_rp + AW'(1);
      r_cnt    <= r_cnt + CW'(w_push) - CW'(w_pop);
      r_starve <= w_starve_nxt;
      r_popped <= w_pop;
      r_stall  <= (r_stall && !r_popped) || (w_starve_nxt == SW'(STARVE_LIMIT));
      r_we     <= w_pipe || w_pop;
      if (w_pipe) begin
        r_waddr <= bus.wb_regDest;
        r_wdata <= bus.wb_result;
      end else if (w_pop) begin
        r_waddr <= r_mem_addr[r_rp];
        r_wdata <= r_mem_data[r_rp];
      end
    end
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed checks of priority, FIFO drain/order, q_busy, starvation and reset.
module tb_wb_port_arbiter;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;
  wb_port_arbiter_if bus ();
  wb_port_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b0;
    bus.wb_regDest = 5'd0;
    bus.wb_result  = 32'd0;
    bus.md_valid   = 1'b0;
    bus.md_regDest = 5'd0;
    bus.md_result  = 32'd0;
    bus.q_addr     = 5'd0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    chk("rst_we", 32'(bus.rf_we), 32'd0);
    chk("rst_waddr", 32'(bus.rf_waddr), 32'd0);
    chk("rst_wdata", bus.rf_wdata, 32'd0);
    chk("rst_stall", 32'(bus.stall_req), 32'd0);
    chk("rst_ready", 32'(bus.md_ready), 32'd1);
    bus.wb_regDest = 5'd5;
    bus.wb_result  = 32'hDEADBEEF;
    tick();
    chk("pipe_we", 32'(bus.rf_we), 32'd1);
    chk("pipe_waddr", 32'(bus.rf_waddr), 32'd5);
    chk("pipe_wdata", bus.rf_wdata, 32'hDEADBEEF);
    bus.wb_regDest = 5'd0;
    tick();
    chk("idle_we", 32'(bus.rf_we), 32'd0);
    chk("idle_waddr_hold", 32'(bus.rf_waddr), 32'd5);
    chk("idle_wdata_hold", bus.rf_wdata, 32'hDEADBEEF);
    bus.q_addr     = 5'd7;
    bus.md_valid   = 1'b1;
    bus.md_regDest = 5'd7;
    bus.md_result  = 32'h11;
    #1 chk("drain_qbusy_N", 32'(bus.q_busy), 32'd0);
    tick();
    bus.md_valid = 1'b0;
    #1 chk("drain_we_N1", 32'(bus.rf_we), 32'd0);
    chk("drain_qbusy_N1", 32'(bus.q_busy), 32'd1);
    tick();
    chk("drain_we_N2", 32'(bus.rf_we), 32'd1);
    chk("drain_waddr_N2", 32'(bus.rf_waddr), 32'd7);
    chk("drain_wdata_N2", bus.rf_wdata, 32'h11);
    chk("drain_qbusy_N2", 32'(bus.q_busy), 32'd0);
    bus.wb_regDest = 5'd3;
    bus.wb_result  = 32'h33;
    bus.md_valid   = 1'b1;
    bus.md_regDest = 5'd1;
    bus.md_result  = 32'hA;
    tick();
    bus.md_regDest = 5'd2;
    bus.md_result  = 32'hB;
    #1 chk("full_ready_c1", 32'(bus.md_ready), 32'd1);
    chk("full_pipe_waddr", 32'(bus.rf_waddr), 32'd3);
    tick();
    bus.md_regDest = 5'd9;
    bus.md_result  = 32'h99;
    #1 chk("full_ready_c2", 32'(bus.md_ready), 32'd0);
    tick();
    chk("full_ready_held", 32'(bus.md_ready), 32'd0);
    chk("full_stall", 32'(bus.stall_req), 32'd0);
    bus.wb_regDest = 5'd0;
    #1 chk("full_ready_release", 32'(bus.md_ready), 32'd0);
    tick();
    chk("order1_we", 32'(bus.rf_we), 32'd1);
    chk("order1_waddr", 32'(bus.rf_waddr), 32'd1);
    chk("order1_wdata", bus.rf_wdata, 32'hA);
    chk("order1_ready", 32'(bus.md_ready), 32'd1);
    bus.q_addr = 5'd9;
    #1 chk("pushing_not_busy", 32'(bus.q_busy), 32'd0);
    tick();
    bus.md_valid = 1'b0;
    chk("order2_waddr", 32'(bus.rf_waddr), 32'd2);
    chk("order2_wdata", bus.rf_wdata, 32'hB);
    chk("order2_ready", 32'(bus.md_ready), 32'd1);
    #1 chk("pushed_busy", 32'(bus.q_busy), 32'd1);
    bus.q_addr = 5'd2;
    #1 chk("popped_not_busy", 32'(bus.q_busy), 32'd0);
    tick();
    chk("order3_we", 32'(bus.rf_we), 32'd1);
    chk("order3_waddr", 32'(bus.rf_waddr), 32'd9);
    chk("order3_wdata", bus.rf_wdata, 32'h99);
    tick();
    chk("order_done_we", 32'(bus.rf_we), 32'd0);
    bus.q_addr     = 5'd0;
    bus.wb_regDest = 5'd4;
    bus.wb_result  = 32'h44;
    bus.md_valid   = 1'b1;
    bus.md_regDest = 5'd6;
    bus.md_result  = 32'h66;
    tick();
    bus.md_valid = 1'b0;
    repeat (3) tick();
    chk("starve_3", 32'(bus.stall_req), 32'd0);
    tick();
    chk("starve_4", 32'(bus.stall_req), 32'd1);
    tick();
    chk("starve_sat", 32'(bus.stall_req), 32'd1);
    chk("starve_pipe_waddr", 32'(bus.rf_waddr), 32'd4);
    bus.wb_regDest = 5'd0;
    tick();
    chk("starve_grant_we", 32'(bus.rf_we), 32'd1);
    chk("starve_grant_waddr", 32'(bus.rf_waddr), 32'd6);
    chk("starve_grant_wdata", bus.rf_wdata, 32'h66);
    chk("starve_grant_stall", 32'(bus.stall_req), 32'd1);
    tick();
    chk("starve_clear", 32'(bus.stall_req), 32'd0);
    chk("starve_clear_we", 32'(bus.rf_we), 32'd0);
    bus.md_valid   = 1'b1;
    bus.md_regDest = 5'd0;
    bus.md_result  = 32'h77;
    #1 chk("zero_ready", 32'(bus.md_ready), 32'd1);
    tick();
    bus.md_valid = 1'b0;
    chk("zero_we1", 32'(bus.rf_we), 32'd0);
    tick();
    chk("zero_we2", 32'(bus.rf_we), 32'd0);
    chk("zero_waddr_hold", 32'(bus.rf_waddr), 32'd6);
    bus.wb_regDest = 5'd4;
    bus.wb_result  = 32'h44;
    bus.md_valid   = 1'b1;
    bus.md_regDest = 5'd8;
    bus.md_result  = 32'h88;
    tick();
    bus.md_regDest = 5'd10;
    bus.md_result  = 32'hAA;
    tick();
    bus.md_valid = 1'b0;
    #1 chk("pre_rst_ready", 32'(bus.md_ready), 32'd0);
    bus.q_addr = 5'd8;
    #1 chk("pre_rst_busy", 32'(bus.q_busy), 32'd1);
    #1 rst = 1'b0;
    #1 chk("arst_we", 32'(bus.rf_we), 32'd0);
    chk("arst_waddr", 32'(bus.rf_waddr), 32'd0);
    chk("arst_wdata", bus.rf_wdata, 32'd0);
    chk("arst_stall", 32'(bus.stall_req), 32'd0);
    chk("arst_ready", 32'(bus.md_ready), 32'd1);
    chk("arst_qbusy", 32'(bus.q_busy), 32'd0);
    bus.wb_regDest = 5'd0;
    rst = 1'b1;
    tick();
    chk("post_rst_we1", 32'(bus.rf_we), 32'd0);
    tick();
    chk("post_rst_we2", 32'(bus.rf_we), 32'd0);
    chk("post_rst_waddr", 32'(bus.rf_waddr), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
